duty_ramp: RTL and testbench

- Duty-setpoint conditioner that sits directly upstream of the PWM stage and drives its 10-bit duty input.
- Takes a raw target duty from the controller and clamps it to the PWM period.
- Slew-limits the duty by STEP counts once per update tick, giving soft-start on enable and soft-stop on disable.
- Forces duty to zero immediately on fault and latches the fault until the enable is cycled.

---
 rtl/duty_ramp_if.sv | 29 ++
 rtl/duty_ramp.sv | 118 +++++++++++
 tb/tb_duty_ramp.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/duty_ramp_if.sv
// duty_ramp_if: groups the controller-facing signals of the duty conditioner.
//   en        run request (level)
//   target    requested duty, unsigned 10-bit
//   fault     fault request (level)
//   d         registered duty to the PWM stage
//   at_target duty has reached the clamped sampled target while running
//   busy      duty is still slewing toward its destination
//   fault_lat fault latched, waiting for fault=0 and en=0
// master: the controller (drives requests, observes duty and flags)
// slave:  the duty_ramp block
interface duty_ramp_if;
    logic       en;
    logic [9:0] target;
    logic       fault;
    logic [9:0] d;
    logic       at_target;
    logic       busy;
    logic       fault_lat;

    modport master (
        output en, target, fault,
        input  d, at_target, busy, fault_lat
    );

    modport slave (
        input  en, target, fault,
        output d, at_target, busy, fault_lat
    );
endinterface

// File: rtl/duty_ramp.sv
// duty_ramp: duty-setpoint conditioner placed directly upstream of the PWM.
// Clamps the requested duty to DMAX, slews the output by at most STEP counts
// once per update tick (every TICK_DIV clocks), ramps down to zero on
// disable, and forces zero immediately on fault, latching the fault until
// en is cycled low with fault released.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   duty   duty_ramp_if.slave: en/target/fault in, d/at_target/busy/fault_lat out
module duty_ramp #(
    parameter int DMAX     = 10,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    duty_ramp_if.slave   duty
);

    localparam int          CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [9:0]  DMAX_C   = 10'(DMAX);
    localparam logic [9:0]  STEP_C   = 10'(STEP);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_FLT  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [9:0]    d_reg, d_next;
    logic [9:0]    tgt_reg, tgt_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          at_target_reg, at_target_next;
    logic          busy_reg, busy_next;
    logic          fault_lat_reg, fault_lat_next;

    logic          tick;
    logic [9:0]    tgt_clamped;
    logic [9:0]    dest;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_OFF;
            d_reg         <= '0;
            tgt_reg       <= '0;
            cnt_reg       <= '0;
            at_target_reg <= 1'b0;
            busy_reg      <= 1'b0;
            fault_lat_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            d_reg         <= d_next;
            tgt_reg       <= tgt_next;
            cnt_reg       <= cnt_next;
            at_target_reg <= at_target_next;
            busy_reg      <= busy_next;
            fault_lat_reg <= fault_lat_next;
        end
    end

    always_comb begin
        // Free-running prescaler; tick marks the last count of each period.
        tick        = (cnt_reg == CNT_LAST);
        cnt_next    = tick ? '0 : cnt_reg + CW'(1);

        tgt_clamped = (duty.target > DMAX_C) ? DMAX_C : duty.target;
        tgt_next    = tick ? tgt_clamped : tgt_reg;

        state_next = state_reg;
        if (duty.fault) begin
            state_next = ST_FLT;
        end else begin
            unique case (state_reg)
                ST_OFF:  if (duty.en) state_next = ST_RUN;
                ST_RUN:  if (!duty.en) state_next = ST_STOP;
                ST_STOP: begin
                    if (duty.en)            state_next = ST_RUN;
                    else if (d_reg == '0)   state_next = ST_OFF;
                end
                ST_FLT:  if (!duty.en) state_next = ST_OFF;
                default: state_next = ST_OFF;
            endcase
        end

        // The slew follows the state being entered on this edge. The run
        // destination is the target captured on an earlier tick, so a new
        // target sampled on this tick is acted on at the following tick.
        dest   = (state_next == ST_RUN) ? tgt_reg : '0;
        d_next = d_reg;
        if (state_next == ST_FLT) begin
            d_next = '0;
        end else if (tick && (state_next == ST_RUN || state_next == ST_STOP)) begin
            // Distance is compared before stepping so d never wraps or
            // steps past the destination.
            if (d_reg < dest) begin
                d_next = ((dest - d_reg) > STEP_C) ? d_reg + STEP_C : dest;
            end else if (d_reg > dest) begin
                d_next = ((d_reg - dest) > STEP_C) ? d_reg - STEP_C : dest;
            end
        end

        // Flags are registered from next-state values so they change on the
        // same edge as d.
        at_target_next = (state_next == ST_RUN) && (d_next == tgt_next);
        busy_next      = ((state_next == ST_RUN)  && (d_next != tgt_next)) ||
                         ((state_next == ST_STOP) && (d_next != '0));
        fault_lat_next = (state_next == ST_FLT);
    end

    assign duty.d         = d_reg;
    assign duty.at_target = at_target_reg;
    assign duty.busy      = busy_reg;
    assign duty.fault_lat = fault_lat_reg;

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: drives two duty_ramp instances (STEP=1 and STEP=3) with the
// same directed and randomized request sequence. A reference model predicts
// each cycle's outputs into per-instance queues; a monitor pops and compares.
module tb_duty_ramp;
    localparam int DMAX = 10;
    localparam int TD   = 10;
    localparam int M_OFF = 0, M_RUN = 1, M_STOP = 2, M_FLT = 3;

    typedef struct {
        int d;
        bit at;
        bit busy;
        bit fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic fault = 1'b0;
    logic [9:0] target = '0;

    int compares = 0;
    int mismatches = 0;

    exp_t q1[$];
    exp_t q3[$];

    int m_st[2];
    int m_d[2];
    int m_tq[2];
    int m_cnt[2];

    always #5 clk = ~clk;

    duty_ramp_if if1 ();
    duty_ramp_if if3 ();

    assign if1.en = en;
    assign if1.target = target;
    assign if1.fault = fault;
    assign if3.en = en;
    assign if3.target = target;
    assign if3.fault = fault;

    duty_ramp #(.DMAX(DMAX), .STEP(1), .TICK_DIV(TD)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (if1)
    );

    duty_ramp #(.DMAX(DMAX), .STEP(3), .TICK_DIV(TD)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (if3)
    );

    // Reference: per clock, what the outputs must be after the coming edge.
    task automatic model_step(input int k);
        int s;
        bit tk;
        int nst;
        int dest;
        exp_t e;
        s = (k == 0) ? 1 : 3;
        if (!rst_n) begin
            m_st[k] = M_OFF;
            m_d[k] = 0;
            m_tq[k] = 0;
            m_cnt[k] = 0;
        end else begin
            tk = (m_cnt[k] == TD - 1);
            m_cnt[k] = (m_cnt[k] + 1) % TD;
            if (fault) nst = M_FLT;
            else if (m_st[k] == M_OFF) nst = en ? M_RUN : M_OFF;
            else if (m_st[k] == M_RUN) nst = en ? M_RUN : M_STOP;
            else if (m_st[k] == M_STOP) nst = en ? M_RUN : ((m_d[k] == 0) ? M_OFF : M_STOP);
            else nst = en ? M_FLT : M_OFF;
            if (nst == M_FLT) begin
                m_d[k] = 0;
            end else if (tk && (nst == M_RUN || nst == M_STOP)) begin
                dest = (nst == M_RUN) ? m_tq[k] : 0;
                if (dest > m_d[k]) m_d[k] = (m_d[k] + s < dest) ? m_d[k] + s : dest;
                else m_d[k] = (m_d[k] - s > dest) ? m_d[k] - s : dest;
            end
            if (tk) m_tq[k] = (int'(target) > DMAX) ? DMAX : int'(target);
            m_st[k] = nst;
        end
        e.d = m_d[k];
        e.at = (m_st[k] == M_RUN) && (m_d[k] == m_tq[k]);
        e.busy = ((m_st[k] == M_RUN) && (m_d[k] != m_tq[k])) ||
                 ((m_st[k] == M_STOP) && (m_d[k] != 0));
        e.fl = (m_st[k] == M_FLT);
        if (k == 0) q1.push_back(e);
        else q3.push_back(e);
    endtask

    // Inputs are set just after a negedge; predict, then let one edge pass.
    task automatic cyc();
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic run_until_d(input int k, input int val, input int bound, input string tag);
        int n;
        n = 0;
        while (m_d[k] != val && n < bound) begin
            cyc();
            n++;
        end
        if (m_d[k] != val) begin
            compares++;
            mismatches++;
            $display("FAIL %s: model d=%0d, required %0d within %0d cycles", tag, m_d[k], val, bound);
        end
    endtask

    task automatic run_until_off(input int bound, input string tag);
        int n;
        n = 0;
        while ((m_st[0] != M_OFF || m_st[1] != M_OFF) && n < bound) begin
            cyc();
            n++;
        end
        if (m_st[0] != M_OFF || m_st[1] != M_OFF) begin
            compares++;
            mismatches++;
            $display("FAIL %s: model states %0d/%0d, required OFF within %0d cycles", tag, m_st[0], m_st[1], bound);
        end
    endtask

    task automatic check(input string name, input exp_t e, input logic [9:0] d,
                         input logic at, input logic busy, input logic fl);
        compares++;
        if (int'(d) != e.d || at !== e.at || busy !== e.busy || fl !== e.fl) begin
            mismatches++;
            $display("FAIL %s @%0t: got d=%0d at=%b busy=%b flt=%b, required d=%0d at=%b busy=%b flt=%b",
                     name, $time, d, at, busy, fl, e.d, e.at, e.busy, e.fl);
        end
    endtask

    // Monitor: outputs are stable one time unit after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut_step1", e, if1.d, if1.at_target, if1.busy, if1.fault_lat);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check("dut_step3", e, if3.d, if3.at_target, if3.busy, if3.fault_lat);
        end
    end

    initial begin
        @(negedge clk);

        // Reset held with a run request pending.
        rst_n = 1'b0; en = 1'b1; target = 10'd7; fault = 1'b0;
        repeat (3) cyc();
        $display("reset: 3 cycles, d1=%0d d3=%0d", m_d[0], m_d[1]);

        // Soft-start to 7.
        rst_n = 1'b1;
        run_until_d(0, 7, 200, "soft_start");
        repeat (15) cyc();
        $display("soft_start: d1=%0d d3=%0d", m_d[0], m_d[1]);

        // Clamp to DMAX, then reverse down to 3.
        target = 10'd900;
        run_until_d(0, 10, 200, "clamp");
        repeat (20) cyc();
        target = 10'd3;
        run_until_d(0, 3, 200, "reverse");
        repeat (20) cyc();
        $display("clamp_reverse: d1=%0d d3=%0d", m_d[0], m_d[1]);

        // Soft-stop from 6 all the way to OFF.
        target = 10'd6;
        run_until_d(0, 6, 200, "to_six");
        en = 1'b0;
        run_until_off(200, "soft_stop");
        repeat (10) cyc();
        $display("soft_stop: d1=%0d d3=%0d", m_d[0], m_d[1]);

        // Stop interrupted at 2 and resumed.
        en = 1'b1; target = 10'd8;
        run_until_d(0, 5, 200, "to_five");
        en = 1'b0;
        run_until_d(0, 2, 200, "stop_to_two");
        en = 1'b1;
        run_until_d(0, 8, 200, "resume");
        repeat (10) cyc();
        $display("stop_resume: d1=%0d d3=%0d", m_d[0], m_d[1]);

        // One-cycle fault with en held; latch until en drops, then re-ramp.
        target = 10'd5;
        run_until_d(0, 5, 200, "to_fault_point");
        fault = 1'b1;
        cyc();
        fault = 1'b0;
        repeat (30) cyc();
        en = 1'b0;
        repeat (5) cyc();
        en = 1'b1; target = 10'd7;
        run_until_d(0, 7, 200, "post_fault_ramp");
        $display("fault: d1=%0d d3=%0d", m_d[0], m_d[1]);

        // Coarse step from 0 to 10 and back down to 1.
        en = 1'b0;
        run_until_off(200, "coarse_off");
        en = 1'b1; target = 10'd10;
        run_until_d(1, 10, 200, "coarse_up");
        repeat (5) cyc();
        target = 10'd1;
        run_until_d(1, 1, 200, "coarse_down");
        repeat (5) cyc();
        $display("coarse_step: d1=%0d d3=%0d", m_d[0], m_d[1]);

        // Randomized requests.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) target = 10'($urandom_range(0, 1023));
            else if ($urandom_range(0, 19) == 0) target = 10'($urandom_range(0, 12));
            if ($urandom_range(0, 59) == 0) en = ~en;
            fault = ($urandom_range(0, 199) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            cyc();
        end
        rst_n = 1'b1; fault = 1'b0;
        $display("random: 3000 cycles, d1=%0d d3=%0d", m_d[0], m_d[1]);

        @(posedge clk);
        #2;
        compares++;
        if (q1.size() != 0 || q3.size() != 0) begin
            mismatches++;
            $display("FAIL drain: %0d/%0d predictions left, required 0/0", q1.size(), q3.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
